sid_reg_spi_slave: RTL and testbench
====================================

Name: sid_reg_spi_slave

Overview:
- SPI mode-0 slave that receives register write/read frames from an external host.
- Maintains the per-voice register bank that drives every voice's frequency, duration, attack, sustain and waveform inputs.
- Provides read-back of all written registers, a chip ID, and a voice-2 output snapshot.
- Sits between the chip pins and the voice instances; it is the writer side of the voice control interface.

Parameters:
- NUM_VOICES, 3, number of voice register groups (max 3).
- CHIP_ID, 8'h65, constant returned at address 0x18.

Ports:
- clk  input  1  system clock.
- rst  input  1  synchronous, active-high reset.
- spi_sclk  input  1  SPI clock, asynchronous to clk.
- spi_cs_n  input  1  SPI chip select, active low, asynchronous.
- spi_mosi  input  1  SPI data in, asynchronous.
- spi_miso  output  1  SPI data out; 0 when idle.
- voice2_in  input  8  voice 2 output, for the snapshot register.
- frequency  output  16*NUM_VOICES  packed; voice v occupies [16v+15:16v].
- duration  output  8*NUM_VOICES  packed pulse width per voice.
- waveform  output  8*NUM_VOICES  packed control/waveform bits per voice.
- attack  output  8*NUM_VOICES  packed attack/decay nibbles per voice.
- sustain  output  8*NUM_VOICES  packed sustain/release nibbles per voice.
- wr_strobe  output  1  one-cycle pulse when a write commits.
- wr_addr  output  5  address of the last committed write; valid with wr_strobe.

Behaviour:
- **Input synchronisation:** all three SPI inputs pass through 2-flop synchronisers in the clk domain. sclk rise/fall and cs_n fall/rise are detected from synchronised samples. The host guarantees each sclk half-period is at least 4 clk cycles.
- **Frame format:** 16 bits, MSB first, sampled on sclk rising edges.
  - bit15 = R/nW (1 = read).
  - bits14:13 ignored.
  - bits12:8 = addr[4:0].
  - bits7:0 = write data (don't-care for reads).
- **Address map:**
  - addr[4:3] = voice v (0..2).
  - addr[2:0]: 0 freq lo, 1 freq hi, 2 duration, 3 waveform, 4 attack, 5 sustain; 6 and 7 reserved.
  - 0x18 = CHIP_ID (read-only). 0x19 = voice2 snapshot (read-only). 0x1A..0x1F reserved.
  - Voices with index ≥ NUM_VOICES are reserved.
  - Writes to reserved or read-only addresses are dropped with no wr_strobe. Reads of reserved addresses return 8'h00.
- **FSM states:**
  - IDLE: wait for synchronised cs_n fall → CMD, bit_cnt = 0.
  - CMD: shift 8 bits. At the 8th rising edge latch rw and addr.
    - Read: load read data into the tx shift register; the voice2 snapshot is captured at this edge. Go to DATA.
    - Write: go to DATA.
  - DATA: shift 8 bits. At the 16th rising edge, a write commits to the register bank the following clk cycle, with wr_strobe = 1 for exactly one cycle. Then go to DONE.
  - DONE: ignore further sclk edges until cs_n rises → IDLE.
  - In any state, a cs_n rise before the 16th edge aborts the frame: no commit, return to IDLE.
- **MISO:**
  - Driven 0 in IDLE and CMD.
  - In a read's DATA state, tx[7] is presented immediately after the 8th rising edge is detected. The shift register advances on each synchronised sclk falling edge.
  - MISO settles within 3 clk cycles of the pin edge.
  - Returns to 0 in DONE, IDLE, and in DATA for writes.
- **Simultaneous events:** if the 16th rising edge and the cs_n rise are detected in the same clk cycle, the frame completes and commits.
- **Reset:**
  - All register-bank outputs reset to 0; spi_miso = 0, wr_strobe = 0, wr_addr = 0. The FSM resets to IDLE with an armed flag cleared.
  - The FSM accepts a frame only after observing synchronised cs_n high while armed. A frame already in progress when reset is released is therefore ignored entirely.
  - Reset mid-frame discards the frame; registers return to 0.
- **Register outputs:** updated only at commit, so all bits of one register change in the same cycle. Latency from the 16th sclk rising pin edge to output update is ≤ 4 clk cycles.
- **Frequency writes:** lo and hi bytes are independent registers. There is no double-buffering; an intermediate frequency value is visible between the two writes.

Decomposition:
- Shared package `sid_pkg`:
  - address offset constants (FREQ_LO=0 … SUSTAIN=5), ADDR_ID=5'h18, ADDR_V2SNAP=5'h19;
  - FSM state encoding (IDLE, CMD, DATA, DONE);
  - FRAME_BITS=16.
- Sub-module `sid_sync_edge`: 2-flop synchroniser plus rise/fall detect, one instance per SPI input (three instances).

Test Plan:
1. After reset, write 0x01←8'hAB and 0x00←8'hCD → frequency[15:0]=16'hABCD; other voices 0; wr_strobe pulses twice with wr_addr 0x01 then 0x00.
2. Write 0x13←8'h41, then read 0x13 → spi_miso shifts 0100_0001 on bits 8-15; waveform[23:16]=8'h41.
3. Read 0x18 → 8'h65. Read 0x19 with voice2_in=8'h3C held → 8'h3C. Read 0x1E → 8'h00; no wr_strobe.
4. Write 0x0A←8'hFF, deasserting cs_n after 12 bits → no wr_strobe; duration[15:8] stays 8'h00. A following complete frame works normally.
5. Write to 0x18 and to 0x06 → no wr_strobe; read-back of 0x06 = 8'h00.
6. Assert rst mid-frame after 10 bits, release while cs_n is still low, finish clocking 6 more bits → nothing commits, all outputs 0. The next full frame after a cs_n high is accepted.

Source files
------------

// File: rtl/sid_pkg.sv
// Shared constants and types for the SID register SPI slave: frame length,
// register offsets within a voice group, special addresses and FSM states.
package sid_pkg;

    localparam int unsigned FRAME_BITS = 16;

    localparam logic [2:0] FREQ_LO  = 3'd0;
    localparam logic [2:0] FREQ_HI  = 3'd1;
    localparam logic [2:0] DURATION = 3'd2;
    localparam logic [2:0] WAVEFORM = 3'd3;
    localparam logic [2:0] ATTACK   = 3'd4;
    localparam logic [2:0] SUSTAIN  = 3'd5;

    localparam logic [4:0] ADDR_ID     = 5'h18;
    localparam logic [4:0] ADDR_V2SNAP = 5'h19;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA,
        DONE
    } spi_state_t;

    // True for a writable voice register that exists in this configuration.
    function automatic logic reg_valid(input logic [4:0] addr, input int unsigned num_voices);
        return (32'(addr[4:3]) < num_voices) && (addr[2:0] <= SUSTAIN);
    endfunction

endpackage

// File: rtl/sid_sync_edge.sv
// Two-flop synchroniser for one asynchronous SPI pin, with rise/fall pulses
// derived from the synchronised level.
module sid_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            sync <= 1'b0;
            prev <= 1'b0;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign level = sync;
    assign rise  = sync & ~prev;
    assign fall  = ~sync & prev;

endmodule

// File: rtl/sid_reg_spi_slave.sv
// SPI mode-0 slave holding the per-voice register bank; 16-bit frames carry
// R/nW, a 5-bit address and a data byte, with read-back on MISO.
module sid_reg_spi_slave
    import sid_pkg::*;
#(
    parameter int unsigned NUM_VOICES = 3,
    parameter logic [7:0]  CHIP_ID    = 8'h65
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      spi_sclk,
    input  logic                      spi_cs_n,
    input  logic                      spi_mosi,
    output logic                      spi_miso,
    input  logic [7:0]                voice2_in,
    output logic [16*NUM_VOICES-1:0]  frequency,
    output logic [8*NUM_VOICES-1:0]   duration,
    output logic [8*NUM_VOICES-1:0]   waveform,
    output logic [8*NUM_VOICES-1:0]   attack,
    output logic [8*NUM_VOICES-1:0]   sustain,
    output logic                      wr_strobe,
    output logic [4:0]                wr_addr
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic cs_level, cs_rise, cs_fall;
    logic mosi_level, mosi_rise, mosi_fall;
    logic unused_edges;

    sid_sync_edge u_sync_sclk (.clk(clk), .rst(rst), .din(spi_sclk),
                               .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall));
    sid_sync_edge u_sync_cs   (.clk(clk), .rst(rst), .din(spi_cs_n),
                               .level(cs_level), .rise(cs_rise), .fall(cs_fall));
    sid_sync_edge u_sync_mosi (.clk(clk), .rst(rst), .din(spi_mosi),
                               .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_edges = ^{sclk_level, mosi_rise, mosi_fall};

    spi_state_t state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;
    logic [6:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [4:0] addr_q, addr_d;
    logic       rw_q, rw_d;
    logic       skip_q, skip_d;
    logic       armed_q, armed_d;
    logic       we;
    logic [7:0] wdata;
    logic [4:0] cmd_addr;
    logic [7:0] read_data;

    logic [7:0] bank [NUM_VOICES][6];

    assign cmd_addr = {rx_q[3:0], mosi_level};
    assign wdata    = {rx_q, mosi_level};

    always_comb begin
        read_data = '0;
        if (cmd_addr == ADDR_ID) begin
            read_data = CHIP_ID;
        end else if (cmd_addr == ADDR_V2SNAP) begin
            read_data = voice2_in;
        end else if (reg_valid(cmd_addr, NUM_VOICES)) begin
            read_data = bank[cmd_addr[4:3]][cmd_addr[2:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            rx_q      <= '0;
            tx_q      <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            skip_q    <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            rx_q      <= rx_d;
            tx_q      <= tx_d;
            addr_q    <= addr_d;
            rw_q      <= rw_d;
            skip_q    <= skip_d;
            armed_q   <= armed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        addr_d    = addr_q;
        rw_d      = rw_q;
        skip_d    = skip_q;
        armed_d   = armed_q | cs_level;
        we        = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall && armed_q) begin
                    state_d   = CMD;
                    bit_cnt_d = '0;
                end
            end
            CMD: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[5:0], mosi_level};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'(FRAME_BITS / 2 - 1)) begin
                        rw_d    = rx_q[6];
                        addr_d  = cmd_addr;
                        tx_d    = read_data;
                        skip_d  = 1'b1;
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                // The final rise wins over a coincident cs_n rise so the frame commits.
                if (sclk_rise && bit_cnt_q == 4'(FRAME_BITS - 1)) begin
                    we      = ~rw_q & reg_valid(addr_q, NUM_VOICES);
                    state_d = cs_rise ? IDLE : DONE;
                end else if (cs_rise) begin
                    state_d = IDLE;
                end else if (sclk_rise) begin
                    rx_d      = {rx_q[5:0], mosi_level};
                    bit_cnt_d = bit_cnt_q + 4'd1;
                end else if (sclk_fall) begin
                    // Hold tx[7] over the fall following the command byte so the
                    // host still sees it on the next rise.
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else begin
                        tx_d = {tx_q[6:0], 1'b0};
                    end
                end
            end
            DONE: begin
                if (cs_rise) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign spi_miso = (state_q == DATA) && rw_q && tx_q[7];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned v = 0; v < NUM_VOICES; v++) begin
                for (int unsigned r = 0; r < 6; r++) begin
                    bank[v][r] <= '0;
                end
            end
            wr_strobe <= 1'b0;
            wr_addr   <= '0;
        end else begin
            wr_strobe <= we;
            if (we) begin
                bank[addr_q[4:3]][addr_q[2:0]] <= wdata;
                wr_addr <= addr_q;
            end
        end
    end

    always_comb begin
        frequency = '0;
        duration  = '0;
        waveform  = '0;
        attack    = '0;
        sustain   = '0;
        for (int unsigned v = 0; v < NUM_VOICES; v++) begin
            frequency[16*v +: 16] = {bank[v][FREQ_HI], bank[v][FREQ_LO]};
            duration[8*v +: 8]    = bank[v][DURATION];
            waveform[8*v +: 8]    = bank[v][WAVEFORM];
            attack[8*v +: 8]      = bank[v][ATTACK];
            sustain[8*v +: 8]     = bank[v][SUSTAIN];
        end
    end

endmodule

// File: tb/tb_sid_reg_spi_slave.sv
// Randomised bench for sid_reg_spi_slave: a bit-banged SPI host against an
// address-indexed byte-array model of the register map.
module tb_sid_reg_spi_slave;

    logic        clk = 1'b0;
    logic        rst;
    logic        spi_sclk, spi_cs_n, spi_mosi, spi_miso;
    logic [7:0]  voice2_in;
    logic [47:0] frequency;
    logic [23:0] duration, waveform, attack, sustain;
    logic        wr_strobe;
    logic [4:0]  wr_addr;

    int unsigned vec_cnt = 0;
    int unsigned err_cnt = 0;

    logic [7:0] mreg [32];
    logic [4:0] strobe_q [$];

    sid_reg_spi_slave #(.NUM_VOICES(3), .CHIP_ID(8'h65)) dut (
        .clk(clk), .rst(rst),
        .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .voice2_in(voice2_in),
        .frequency(frequency), .duration(duration), .waveform(waveform),
        .attack(attack), .sustain(sustain),
        .wr_strobe(wr_strobe), .wr_addr(wr_addr)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_strobe) strobe_q.push_back(wr_addr);
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit writable(input logic [4:0] a);
        return (a[4:3] != 2'd3) && (a[2:0] < 3'd6);
    endfunction

    function automatic logic [7:0] model_read(input logic [4:0] a, input logic [7:0] v2);
        if (a == 5'h18) return 8'h65;
        if (a == 5'h19) return v2;
        if (writable(a)) return mreg[a];
        return 8'h00;
    endfunction

    task automatic half();
        repeat ($urandom_range(4, 7)) @(posedge clk);
        #2;
    endtask

    task automatic spi_bit(input logic b, output logic sampled);
        spi_mosi = b;
        half();
        sampled  = spi_miso;
        spi_sclk = 1'b1;
        half();
        spi_sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [15:0] word, input int nbits, output logic [7:0] rx);
        logic s;
        rx = '0;
        spi_cs_n = 1'b0;
        half();
        for (int i = 0; i < nbits; i++) begin
            spi_bit(word[15-i], s);
            if (i >= 8) rx = {rx[6:0], s};
        end
        half();
        spi_cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
    endtask

    task automatic check_outputs(input string tag);
        logic [47:0] ef;
        logic [23:0] ed, ew, ea, es;
        for (int v = 0; v < 3; v++) begin
            ef[16*v +: 16] = {mreg[8*v+1], mreg[8*v]};
            ed[8*v +: 8]   = mreg[8*v+2];
            ew[8*v +: 8]   = mreg[8*v+3];
            ea[8*v +: 8]   = mreg[8*v+4];
            es[8*v +: 8]   = mreg[8*v+5];
        end
        check({tag, ".frequency"}, frequency, ef);
        check({tag, ".duration"}, duration, ed);
        check({tag, ".waveform"}, waveform, ew);
        check({tag, ".attack"}, attack, ea);
        check({tag, ".sustain"}, sustain, es);
        check({tag, ".miso_idle"}, spi_miso, 0);
    endtask

    task automatic do_frame(input string tag, input logic rw, input logic [4:0] a,
                            input logic [7:0] d, input int nbits);
        logic [7:0] rx;
        logic [7:0] exp_rd;
        exp_rd = model_read(a, voice2_in);
        strobe_q.delete();
        spi_xfer({rw, 2'b00, a, d}, nbits, rx);
        if (nbits == 16 && !rw && writable(a)) begin
            mreg[a] = d;
            check({tag, ".strobe_cnt"}, strobe_q.size(), 1);
            if (strobe_q.size() >= 1) check({tag, ".wr_addr"}, strobe_q[0], a);
        end else begin
            check({tag, ".strobe_cnt"}, strobe_q.size(), 0);
        end
        if (nbits == 16 && rw) check({tag, ".rdata"}, rx, exp_rd);
        check_outputs(tag);
    endtask

    initial begin
        logic s;
        rst = 1'b1;
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        spi_mosi = 1'b0;
        voice2_in = 8'h00;
        for (int i = 0; i < 32; i++) mreg[i] = 8'h00;
        repeat (5) @(posedge clk);
        #2;
        check("reset.wr_strobe", wr_strobe, 0);
        check("reset.wr_addr", wr_addr, 0);
        check_outputs("reset");
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #2;

        do_frame("t1.wr01", 1'b0, 5'h01, 8'hAB, 16);
        do_frame("t1.wr00", 1'b0, 5'h00, 8'hCD, 16);
        check("t1.freq0", frequency[15:0], 16'hABCD);

        do_frame("t2.wr13", 1'b0, 5'h13, 8'h41, 16);
        do_frame("t2.rd13", 1'b1, 5'h13, 8'h00, 16);

        do_frame("t3.id", 1'b1, 5'h18, 8'h00, 16);
        voice2_in = 8'h3C;
        do_frame("t3.snap", 1'b1, 5'h19, 8'h00, 16);
        do_frame("t3.rsvd", 1'b1, 5'h1E, 8'h00, 16);

        do_frame("t4.abort", 1'b0, 5'h0A, 8'hFF, 12);
        do_frame("t4.next", 1'b0, 5'h0A, 8'h5A, 16);

        do_frame("t5.wr18", 1'b0, 5'h18, 8'h77, 16);
        do_frame("t5.wr06", 1'b0, 5'h06, 8'h99, 16);
        do_frame("t5.rd06", 1'b1, 5'h06, 8'h00, 16);

        // Reset in the middle of a frame, released while cs_n is still low.
        strobe_q.delete();
        spi_cs_n = 1'b0;
        half();
        for (int i = 0; i < 10; i++) spi_bit(1'b0, s);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        for (int i = 0; i < 6; i++) spi_bit(1'b1, s);
        half();
        spi_cs_n = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        for (int i = 0; i < 32; i++) mreg[i] = 8'h00;
        check("t6.strobe_cnt", strobe_q.size(), 0);
        check("t6.wr_addr", wr_addr, 0);
        check_outputs("t6");
        do_frame("t6.after", 1'b0, 5'h04, 8'hC3, 16);

        for (int n = 0; n < 50; n++) begin
            logic [4:0] a;
            int         nbits;
            a = 5'($urandom_range(0, 31));
            nbits = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 15)) : 16;
            voice2_in = 8'($urandom);
            do_frame("rand", 1'($urandom_range(0, 1)), a, 8'($urandom), nbits);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    initial begin
        #20ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
